mem_copy_engine: RTL and testbench

- Block-copy DMA engine directly upstream of the 256x16 dual-write-port memory.
- Drives the memory's port B write interface and port_sel; reads source words from the memory's combinational data_q output.
- Host logic keeps port A. A host_req input gives the host priority access; while it is high the engine pauses.

---
 rtl/mem_copy_engine.sv | 169 ++++++++++++++++
 tb/tb_mem_copy_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Block-copy DMA engine that sits directly upstream of a dual-write-port
//   memory. The engine owns port B and port_sel. It reads source words from
//   the memory's combinational data_q and writes them back through port B.
//   The host keeps port A. While host_req is high the engine pauses, so the
//   host has priority access to the memory.
//
//   Each word takes two cycles: READ latches data_q into a buffer, and WRITE
//   drives that buffer onto port B. The memory samples the write at the end
//   of the WRITE cycle.
//
// Optional feature: define MEM_COPY_CHECKSUM_EN to add the checksum output.
//   It holds the modulo-2**DW sum of every word written by the current copy.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     one-cycle copy request, sampled only in IDLE
//   src_addr  first source word address
//   dst_addr  first destination word address
//   len       words to copy; 0 encodes 2**AW
//   host_req  host needs port A this cycle; engine yields
//   data_q    memory read data for the currently selected address
//   port_sel  memory port select, 1 = engine (port B)
//   we_b      port B write enable
//   addr_wb   port B address
//   data_wb   port B write data
//   busy      high in READ, WRITE and DONE
//   done      one-cycle completion pulse
//   checksum  (MEM_COPY_CHECKSUM_EN only) sum of copied words
//
// Handshake: start is a single-cycle request with no ready. It is accepted
//   only when the engine is idle (busy low) and ignored otherwise. done
//   pulses for one cycle when the last word has been written.
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic          host_req,
  input  logic [DW-1:0] data_q,
  output logic          port_sel,
  output logic          we_b,
  output logic [AW-1:0] addr_wb,
  output logic [DW-1:0] data_wb,
  output logic          busy,
  output logic          done
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A zero length field means a full memory sweep.
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t        state, state_nx;
  logic [AW:0]   cnt;
  logic [AW-1:0] src_r, dst_r, len_r;
  logic [DW-1:0] buf_r;
  logic [AW:0]   len_eff;
  logic          last_word;

  assign len_eff   = (len_r == '0) ? DEPTH : {1'b0, len_r};
  assign last_word = (cnt == len_eff - (AW+1)'(1));

  // State register and datapath. While host_req stalls READ or WRITE,
  // state, cnt and buf all hold, so the engine repeats that same step
  // once the host lets go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      src_r <= '0;
      dst_r <= '0;
      len_r <= '0;
      buf_r <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_r <= src_addr;
            dst_r <= dst_addr;
            len_r <= len;
            cnt   <= '0;
          end
        end
        S_READ: begin
          if (!host_req) buf_r <= data_q;
        end
        S_WRITE: begin
          if (!host_req && !last_word) cnt <= cnt + (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  if (!host_req) state_nx = S_WRITE;
      S_WRITE: if (!host_req) state_nx = last_word ? S_DONE : S_READ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state register, so they stay stable for
  // the whole cycle. The only exception is host_req, which must take the
  // port back from the engine within the same cycle.
  always_comb begin
    port_sel = 1'b0;
    we_b     = 1'b0;
    addr_wb  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_READ: begin
        busy     = 1'b1;
        port_sel = !host_req;
        addr_wb  = src_r + cnt[AW-1:0];
      end
      S_WRITE: begin
        busy     = 1'b1;
        port_sel = !host_req;
        we_b     = !host_req;
        addr_wb  = dst_r + cnt[AW-1:0];
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign data_wb = buf_r;

`ifdef MEM_COPY_CHECKSUM_EN
  // Clears on an accepted start and adds every word that is actually
  // written. The value then holds from DONE until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == S_IDLE && start) begin
      checksum <= '0;
    end else if (state == S_WRITE && !host_req) begin
      checksum <= checksum + buf_r;
    end
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed testbench for mem_copy_engine. The bench holds a 256x16 memory
// model: port A belongs to the bench (the host) and port B to the engine.
// An expected-memory shadow array tracks what the memory should contain.
module tb_mem_copy_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [7:0]  src_addr, dst_addr, len;
  logic        host_req;
  logic [15:0] data_q;
  logic        port_sel, we_b;
  logic [7:0]  addr_wb;
  logic [15:0] data_wb;
  logic        busy, done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  mem_copy_engine #(.AW(8), .DW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .host_req (host_req),
    .data_q   (data_q),
    .port_sel (port_sel),
    .we_b     (we_b),
    .addr_wb  (addr_wb),
    .data_wb  (data_wb),
    .busy     (busy),
    .done     (done)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  // ---------------- memory model ----------------
  logic [15:0] mem [256];
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_data;

  always @(posedge clk) begin
    if (port_sel && we_b) mem[addr_wb] <= data_wb;
    else if (host_we)     mem[host_addr] <= host_data;
  end

  assign data_q = mem[port_sel ? addr_wb : host_addr];

  // ---------------- scoreboard ----------------
  logic [15:0] exp_mem [256];
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cyc;
  logic [15:0] cs_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic host_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_data = d;
    @(posedge clk);
    #1 host_we = 1'b0;
    exp_mem[a] = d;
  endtask

  // Forward word-by-word copy on the expected image (overlap propagates).
  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    int n;
    n = (l == 8'd0) ? 256 : int'(l);
    for (int j = 0; j < n; j++) exp_mem[8'(d + j)] = exp_mem[8'(s + j)];
  endtask

  task automatic check_mem_all(input string tag);
    for (int i = 0; i < 256; i++) exp_q.push_back(exp_mem[i]);
    for (int i = 0; i < 256; i++)
      check($sformatf("%s_mem[%0h]", tag, i), mem[i], exp_q.pop_front());
  endtask

  // Drives start so that the next rising edge (edge k) samples it.
  task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
  endtask

  // Runs cycles k+1, k+2, ... until done is seen or the cycle limit is hit.
  // host_req is held for cycles [hr_at, hr_at+hr_n). A second start with
  // other addresses is pulsed in cycle rs_at (0 = never).
  task automatic run_to_done(input string tag, input int hr_at, input int hr_n,
                             input int rs_at, input int exp_done);
    done_cyc = 0;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk);
      #1;
      start    = (c == rs_at);
      if (c == rs_at) begin
        src_addr = 8'h40; dst_addr = 8'hB0; len = 8'd4;
      end
      host_req = (c >= hr_at) && (c < hr_at + hr_n);
      @(negedge clk);
      if (host_req) begin
        check($sformatf("%s_stall_port_sel_c%0d", tag, c), port_sel, 1'b0);
        check($sformatf("%s_stall_we_b_c%0d", tag, c), we_b, 1'b0);
      end
      if (done) begin
        done_cyc = c;
`ifdef MEM_COPY_CHECKSUM_EN
        cs_at_done = checksum;
`endif
        break;
      end
    end
    start = 1'b0; host_req = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_done_after"}, done, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_data = '0;
    cs_at_done = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_port_sel", port_sel, 1'b0);
    check("rst_we_b", we_b, 1'b0);
    check("rst_addr_wb", addr_wb, 8'h00);
    check("rst_data_wb", data_wb, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
`ifdef MEM_COPY_CHECKSUM_EN
    check("rst_checksum", checksum, 16'h0000);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Known background contents.
    for (int i = 0; i < 256; i++) host_write(8'(i), 16'hC000 | 16'(i));

    // Test 1: four-word copy, checked cycle by cycle.
    host_write(8'h10, 16'h1111);
    host_write(8'h11, 16'h2222);
    host_write(8'h12, 16'h3333);
    host_write(8'h13, 16'h4444);
    launch(8'h10, 8'h80, 8'd4);
    begin
      logic [15:0] t1_words [4];
      t1_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check($sformatf("t1_we_b_c%0d", c), we_b, (c % 2 == 0) && (c <= 8));
        check($sformatf("t1_done_c%0d", c), done, c == 9);
        check($sformatf("t1_busy_c%0d", c), busy, c <= 9);
        if ((c % 2 == 0) && (c <= 8)) begin
          check($sformatf("t1_addr_c%0d", c), addr_wb, 8'h80 + 8'(c / 2 - 1));
          check($sformatf("t1_data_c%0d", c), data_wb, t1_words[c / 2 - 1]);
        end
      end
    end
    model_copy(8'h10, 8'h80, 8'd4);
    check_mem_all("t1");

    // Test 2: len=0 (256 words) with source wrap. Because dst lies inside
    // the source window, already-copied words are re-read.
    for (int i = 0; i < 256; i++) host_write(8'(i), 16'(i));
    launch(8'hF0, 8'h00, 8'd0);
    run_to_done("t2", 0, 0, 0, 513);
    model_copy(8'hF0, 8'h00, 8'd0);
    check("t2_mem00", mem[8'h00], 16'h00F0);
    check("t2_mem0f", mem[8'h0F], 16'h00FF);
    check_mem_all("t2");

    // Test 3: host_req during the second WRITE stretches the copy by 3 cycles.
    for (int i = 0; i < 4; i++) host_write(8'h20 + 8'(i), 16'hA0A0 + 16'(i * 7));
    launch(8'h20, 8'h90, 8'd4);
    run_to_done("t3", 4, 3, 0, 12);
    model_copy(8'h20, 8'h90, 8'd4);
    check_mem_all("t3");

    // Test 4: second start while busy is ignored.
    for (int i = 0; i < 4; i++) host_write(8'h30 + 8'(i), 16'h5150 + 16'(i));
    launch(8'h30, 8'hA0, 8'd4);
    run_to_done("t4", 0, 0, 3, 9);
    model_copy(8'h30, 8'hA0, 8'd4);
    check_mem_all("t4");

    // Test 5: asynchronous reset mid-copy, after the second word is written.
    for (int i = 0; i < 8; i++) host_write(8'h50 + 8'(i), 16'h7700 + 16'(i));
    launch(8'h50, 8'hC0, 8'd8);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_port_sel", port_sel, 1'b0);
    check("t5_we_b", we_b, 1'b0);
    check("t5_addr_wb", addr_wb, 8'h00);
    check("t5_data_wb", data_wb, 16'h0000);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t5_no_done_%0d", c), done, 1'b0);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t5_idle_busy_%0d", c), busy, 1'b0);
    end
    model_copy(8'h50, 8'hC0, 8'd2);
    check_mem_all("t5");

`ifdef MEM_COPY_CHECKSUM_EN
    // Test 6: checksum wraps modulo 2**16.
    host_write(8'h60, 16'hFFFF);
    host_write(8'h61, 16'h0002);
    host_write(8'h62, 16'h0010);
    launch(8'h60, 8'hD0, 8'd3);
    run_to_done("t6", 0, 0, 0, 7);
    check("t6_checksum_done", cs_at_done, 16'h0011);
    check("t6_checksum_held", checksum, 16'h0011);
    model_copy(8'h60, 8'hD0, 8'd3);
    check_mem_all("t6");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
